lsu: RTL and testbench

Load/store stage that sits directly downstream of the execute stage and upstream of write-back. It latches one executed instruction per valid/ready handshake and performs any memory access over a simple request/response data bus. Loads are shifted, masked and sign-extended before being forwarded; non-memory instructions pass straight through. It holds exactly one instruction at a time.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_if.sv | 23 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 195 +++++++++++++++++++
 tb/tb_lsu.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared widths, FSM state encoding and access-size mask constants for the lsu.
package lsu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned STRB_W     = XLEN / 8;
  localparam int unsigned WMASK_IN_W = 8;
  localparam int unsigned WDOP_W     = 2;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned CSR_RD_W   = 2;

  localparam logic [XLEN-1:0]   RMASK_B = 32'h0000_00FF;
  localparam logic [XLEN-1:0]   RMASK_H = 32'h0000_FFFF;
  localparam logic [XLEN-1:0]   RMASK_W = 32'hFFFF_FFFF;

  localparam logic [STRB_W-1:0] WMASK_B = 4'h1;
  localparam logic [STRB_W-1:0] WMASK_H = 4'h3;
  localparam logic [STRB_W-1:0] WMASK_W = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response data-bus between the lsu (master) and memory (slave).
interface lsu_if;

  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [lsu_pkg::XLEN-1:0]     mem_addr;
  logic                         mem_wen;
  logic [lsu_pkg::XLEN-1:0]     mem_wdata;
  logic [lsu_pkg::STRB_W-1:0]   mem_wstrb;
  logic                         mem_resp_valid;
  logic [lsu_pkg::XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store shift/strobes, load extract/extend, misalign check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [STRB_W-1:0] i_wmask,
  input  logic [XLEN-1:0]   i_rmask,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic              i_signed,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_load_data,
  output logic              o_misalign
);

  logic [1:0]      w_off;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_extract;
  logic            w_half;
  logic            w_word;

  assign w_off      = i_addr[1:0];
  assign w_shamt    = {w_off, 3'b000};
  assign o_mem_addr = {i_addr[XLEN-1:2], 2'b00};
  assign o_wdata    = i_wdata << w_shamt;
  assign o_wstrb    = i_wmask << w_off;
  assign w_extract  = (i_rdata >> w_shamt) & i_rmask;

  // Access size comes from the load mask when ren is set (loads win over stores).
  always_comb begin
    w_half     = i_ren ? (i_rmask == RMASK_H) : (i_wmask == WMASK_H);
    w_word     = i_ren ? (i_rmask == RMASK_W) : (i_wmask == WMASK_W);
    o_misalign = (i_ren | i_wen) &
                 ((w_half & w_off[0]) | (w_word & (w_off != 2'b00)));
  end

  // Sign-extend sub-word loads from their top bit.
  always_comb begin
    o_load_data = w_extract;
    if (i_signed) begin
      if (i_rmask == RMASK_B) begin
        o_load_data = {{(XLEN-8){w_extract[7]}}, w_extract[7:0]};
      end else if (i_rmask == RMASK_H) begin
        o_load_data = {{(XLEN-16){w_extract[15]}}, w_extract[15:0]};
      end
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: holds one executed instruction, runs its bus access, forwards to write-back.
module lsu
  import lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_receive_valid,
  output logic                  lsu_send_ready,
  input  logic [XLEN-1:0]       alu_result_input,
  input  logic [XLEN-1:0]       src2_input,
  input  logic                  ren_input,
  input  logic                  wen_input,
  input  logic [WMASK_IN_W-1:0] wmask_input,
  input  logic [XLEN-1:0]       rmask_input,
  input  logic                  memory_read_signed_input,
  input  logic                  reg_write_en_input,
  input  logic                  csreg_write_en_input,
  input  logic                  csrwdOp_input,
  input  logic                  ecall_input,
  input  logic [WDOP_W-1:0]     wdOp_input,
  input  logic [XLEN-1:0]       pc_input,
  input  logic [RD_W-1:0]       rd_input,
  input  logic [CSR_RD_W-1:0]   csr_rd_input,
  lsu_if.master                 bus,
  output logic                  lsu_send_valid,
  input  logic                  lsu_receive_ready,
  output logic [XLEN-1:0]       load_data,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       pc,
  output logic [RD_W-1:0]       rd,
  output logic [WDOP_W-1:0]     wdOp,
  output logic [CSR_RD_W-1:0]   csr_rd,
  output logic                  reg_write_en,
  output logic                  csreg_write_en,
  output logic                  csrwdOp,
  output logic                  ecall,
  output logic                  misalign
);

  lsu_state_e          r_state;
  logic                r_send_valid;
  logic [XLEN-1:0]     r_load_data;
  logic [XLEN-1:0]     r_alu_result;
  logic [XLEN-1:0]     r_pc;
  logic [RD_W-1:0]     r_rd;
  logic [WDOP_W-1:0]   r_wdop;
  logic [CSR_RD_W-1:0] r_csr_rd;
  logic                r_reg_write_en;
  logic                r_csreg_write_en;
  logic                r_csrwdop;
  logic                r_ecall;
  logic                r_misalign;
  logic [XLEN-1:0]     r_rmask;
  logic                r_signed;
  logic                r_ren;
  logic                r_mem_req_valid;
  logic [XLEN-1:0]     r_mem_addr;
  logic                r_mem_wen;
  logic [XLEN-1:0]     r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;

  logic                w_idle;
  logic [XLEN-1:0]     w_addr;
  logic [XLEN-1:0]     w_rmask;
  logic                w_signed;
  logic [XLEN-1:0]     w_mem_addr;
  logic [XLEN-1:0]     w_wdata;
  logic [STRB_W-1:0]   w_wstrb;
  logic [XLEN-1:0]     w_load_data;
  logic                w_misalign;
  logic                w_unused_wmask;

  // Aligner sees the incoming instruction in IDLE and the held one afterwards.
  assign w_idle         = (r_state == IDLE);
  assign w_addr         = w_idle ? alu_result_input         : r_alu_result;
  assign w_rmask        = w_idle ? rmask_input              : r_rmask;
  assign w_signed       = w_idle ? memory_read_signed_input : r_signed;
  assign w_unused_wmask = ^wmask_input[WMASK_IN_W-1:STRB_W];

  lsu_align u_align (
    .i_addr      (w_addr),
    .i_wdata     (src2_input),
    .i_wmask     (wmask_input[STRB_W-1:0]),
    .i_rmask     (w_rmask),
    .i_ren       (ren_input),
    .i_wen       (wen_input),
    .i_signed    (w_signed),
    .i_rdata     (bus.mem_rdata),
    .o_mem_addr  (w_mem_addr),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );

  // Instruction FSM with all bus and downstream outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_send_valid     <= 1'b0;
      r_load_data      <= '0;
      r_alu_result     <= '0;
      r_pc             <= '0;
      r_rd             <= '0;
      r_wdop           <= '0;
      r_csr_rd         <= '0;
      r_reg_write_en   <= 1'b0;
      r_csreg_write_en <= 1'b0;
      r_csrwdop        <= 1'b0;
      r_ecall          <= 1'b0;
      r_misalign       <= 1'b0;
      r_rmask          <= '0;
      r_signed         <= 1'b0;
      r_ren            <= 1'b0;
      r_mem_req_valid  <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wen        <= 1'b0;
      r_mem_wdata      <= '0;
      r_mem_wstrb      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lsu_receive_valid) begin
            r_alu_result     <= alu_result_input;
            r_pc             <= pc_input;
            r_rd             <= rd_input;
            r_wdop           <= wdOp_input;
            r_csr_rd         <= csr_rd_input;
            r_reg_write_en   <= reg_write_en_input;
            r_csreg_write_en <= csreg_write_en_input;
            r_csrwdop        <= csrwdOp_input;
            r_ecall          <= ecall_input;
            r_rmask          <= rmask_input;
            r_signed         <= memory_read_signed_input;
            r_ren            <= ren_input;
            r_misalign       <= w_misalign;
            r_load_data      <= '0;
            if ((ren_input || wen_input) && !w_misalign) begin
              r_state         <= REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= w_mem_addr;
              r_mem_wen       <= !ren_input && wen_input;
              r_mem_wdata     <= ren_input ? '0 : w_wdata;
              r_mem_wstrb     <= ren_input ? '0 : w_wstrb;
            end else begin
              r_state      <= DONE;
              r_send_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_state         <= WAIT;
            r_mem_req_valid <= 1'b0;
            r_mem_wen       <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            r_state      <= DONE;
            r_send_valid <= 1'b1;
            r_load_data  <= r_ren ? w_load_data : '0;
          end
        end
        DONE: begin
          if (lsu_receive_ready) begin
            r_state      <= IDLE;
            r_send_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_send_ready    = w_idle;
  assign lsu_send_valid    = r_send_valid;
  assign load_data         = r_load_data;
  assign alu_result        = r_alu_result;
  assign pc                = r_pc;
  assign rd                = r_rd;
  assign wdOp              = r_wdop;
  assign csr_rd            = r_csr_rd;
  assign reg_write_en      = r_reg_write_en;
  assign csreg_write_en    = r_csreg_write_en;
  assign csrwdOp           = r_csrwdop;
  assign ecall             = r_ecall;
  assign misalign          = r_misalign;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wen       = r_mem_wen;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wstrb     = r_mem_wstrb;

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomized bench for lsu against a byte-level reference model.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_receive_valid;
  logic        lsu_send_ready;
  logic [31:0] alu_result_input, src2_input, rmask_input, pc_input;
  logic        ren_input, wen_input, memory_read_signed_input;
  logic [7:0]  wmask_input;
  logic        reg_write_en_input, csreg_write_en_input, csrwdOp_input, ecall_input;
  logic [1:0]  wdOp_input, csr_rd_input;
  logic [4:0]  rd_input;
  logic        lsu_send_valid, lsu_receive_ready;
  logic [31:0] load_data, alu_result, pc;
  logic [4:0]  rd;
  logic [1:0]  wdOp, csr_rd;
  logic        reg_write_en, csreg_write_en, csrwdOp, ecall, misalign;

  int n_checks = 0;
  int n_errors = 0;

  // Applied instruction and model expectations
  logic [31:0] a_alu, a_pc;
  logic [4:0]  a_rd;
  logic [1:0]  a_wdop, a_csr_rd;
  logic        a_rwe, a_cwe, a_cop, a_ecall;
  logic        e_mem, e_mis, e_wen;
  logic [31:0] e_maddr, e_wdata, e_load;
  logic [3:0]  e_strb;

  always #5 clk = ~clk;

  lsu_if bus();

  lsu dut (
    .clk                      (clk),
    .rst                      (rst),
    .lsu_receive_valid        (lsu_receive_valid),
    .lsu_send_ready           (lsu_send_ready),
    .alu_result_input         (alu_result_input),
    .src2_input               (src2_input),
    .ren_input                (ren_input),
    .wen_input                (wen_input),
    .wmask_input              (wmask_input),
    .rmask_input              (rmask_input),
    .memory_read_signed_input (memory_read_signed_input),
    .reg_write_en_input       (reg_write_en_input),
    .csreg_write_en_input     (csreg_write_en_input),
    .csrwdOp_input            (csrwdOp_input),
    .ecall_input              (ecall_input),
    .wdOp_input               (wdOp_input),
    .pc_input                 (pc_input),
    .rd_input                 (rd_input),
    .csr_rd_input             (csr_rd_input),
    .bus                      (bus),
    .lsu_send_valid           (lsu_send_valid),
    .lsu_receive_ready        (lsu_receive_ready),
    .load_data                (load_data),
    .alu_result               (alu_result),
    .pc                       (pc),
    .rd                       (rd),
    .wdOp                     (wdOp),
    .csr_rd                   (csr_rd),
    .reg_write_en             (reg_write_en),
    .csreg_write_en           (csreg_write_en),
    .csrwdOp                  (csrwdOp),
    .ecall                    (ecall),
    .misalign                 (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane offset, byte-wise load assembly.
  task automatic model(input logic [31:0] addr, input logic [31:0] src2, input logic [31:0] rmask,
                       input logic [7:0] wmask, input logic ren, input logic wen,
                       input logic sgn, input logic [31:0] rdata);
    int unsigned bytes, off;
    logic is_load, is_store;
    is_load  = ren;
    is_store = !ren && wen;
    if (is_load) bytes = (rmask == 32'hFF) ? 1 : (rmask == 32'hFFFF) ? 2 : 4;
    else         bytes = (wmask[3:0] == 4'h1) ? 1 : (wmask[3:0] == 4'h3) ? 2 : 4;
    off     = addr % 4;
    e_mis   = (is_load || is_store) && ((addr % bytes) != 0);
    e_mem   = (is_load || is_store) && !e_mis;
    e_maddr = addr - off;
    e_wen   = is_store;
    e_wdata = is_store ? (src2 << (8 * off)) : 32'h0;
    e_strb  = 4'h0;
    e_load  = 32'h0;
    if (e_mem && is_store)
      for (int b = 0; b < int'(bytes); b++) e_strb[int'(off) + b] = 1'b1;
    if (e_mem && is_load) begin
      for (int b = 0; b < int'(bytes); b++)
        e_load |= ((rdata >> (8 * (int'(off) + b))) & 32'hFF) << (8 * b);
      if (sgn && bytes < 4 && e_load[8 * bytes - 1])
        e_load |= ~((32'h1 << (8 * bytes)) - 32'h1);
    end
  endtask

  task automatic scramble();
    alu_result_input = $urandom; src2_input = $urandom; pc_input = $urandom;
    rmask_input = $urandom; wmask_input = 8'($urandom); rd_input = 5'($urandom);
    ren_input = 1'b0; wen_input = 1'b0; memory_read_signed_input = 1'($urandom);
  endtask

  task automatic check_done(input int h);
    chk($sformatf("done_send_valid[%0d]", h), 32'(lsu_send_valid), 32'd1);
    chk("done_send_ready", 32'(lsu_send_ready), 32'd0);
    chk("done_alu_result", alu_result, a_alu);
    chk("done_pc", pc, a_pc);
    chk("done_rd", 32'(rd), 32'(a_rd));
    chk("done_wdOp", 32'(wdOp), 32'(a_wdop));
    chk("done_csr_rd", 32'(csr_rd), 32'(a_csr_rd));
    chk("done_flags", 32'({reg_write_en, csreg_write_en, csrwdOp, ecall}),
        32'({a_rwe, a_cwe, a_cop, a_ecall}));
    chk("done_load_data", load_data, e_load);
    chk("done_misalign", 32'(misalign), 32'(e_mis));
    chk("done_req_valid", 32'(bus.mem_req_valid), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] addr, input logic [31:0] src2, input logic [31:0] rmask,
                        input logic [7:0] wmask, input logic ren, input logic wen, input logic sgn,
                        input logic [31:0] rdata, input logic [4:0] rdn,
                        input int req_stall, input int resp_delay, input int hold);
    model(addr, src2, rmask, wmask, ren, wen, sgn, rdata);
    @(negedge clk);
    chk("idle_send_ready", 32'(lsu_send_ready), 32'd1);
    a_alu = addr; a_pc = $urandom; a_rd = rdn; a_wdop = 2'($urandom); a_csr_rd = 2'($urandom);
    a_rwe = 1'($urandom); a_cwe = 1'($urandom); a_cop = 1'($urandom); a_ecall = 1'($urandom);
    alu_result_input = addr; src2_input = src2; rmask_input = rmask; wmask_input = wmask;
    ren_input = ren; wen_input = wen; memory_read_signed_input = sgn;
    pc_input = a_pc; rd_input = a_rd; wdOp_input = a_wdop; csr_rd_input = a_csr_rd;
    reg_write_en_input = a_rwe; csreg_write_en_input = a_cwe;
    csrwdOp_input = a_cop; ecall_input = a_ecall;
    lsu_receive_valid = 1'b1;
    @(negedge clk);
    lsu_receive_valid = 1'b0;
    scramble();
    if (e_mem) begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("req_addr", bus.mem_addr, e_maddr);
        chk("req_wen", 32'(bus.mem_wen), 32'(e_wen));
        if (e_wen) begin
          chk("req_wdata", bus.mem_wdata, e_wdata);
          chk("req_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
        end
        chk("req_send_valid", 32'(lsu_send_valid), 32'd0);
        chk("req_send_ready", 32'(lsu_send_ready), 32'd0);
        bus.mem_req_ready = (i == req_stall);
        @(negedge clk);
      end
      bus.mem_req_ready = 1'b0;
      for (int j = 0; j <= resp_delay; j++) begin
        chk("wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("wait_send_valid", 32'(lsu_send_valid), 32'd0);
        bus.mem_resp_valid = (j == resp_delay);
        bus.mem_rdata      = (j == resp_delay) ? rdata : $urandom;
        @(negedge clk);
      end
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = $urandom;
    end
    for (int h = 0; h <= hold; h++) begin
      check_done(h);
      lsu_receive_ready = (h == hold);
      @(negedge clk);
    end
    lsu_receive_ready = 1'b0;
    chk("release_send_valid", 32'(lsu_send_valid), 32'd0);
    chk("release_send_ready", 32'(lsu_send_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r_addr, r_rmask;
    logic [7:0]  r_wmask;
    int          k, s;
    rst = 1'b0;
    lsu_receive_valid = 1'b0; lsu_receive_ready = 1'b0;
    reg_write_en_input = 1'b0; csreg_write_en_input = 1'b0;
    csrwdOp_input = 1'b0; ecall_input = 1'b0; wdOp_input = 2'b0; csr_rd_input = 2'b0;
    scramble();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_send_valid", 32'(lsu_send_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_alu_result", alu_result, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b1;

    // ALU passthrough
    run_op(32'h1234, 32'h0, RMASK_W, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 0, 0, 0);
    // Signed byte load from lane 3
    run_op(32'h8000_0003, 32'h0, RMASK_B, 8'h0, 1'b1, 1'b0, 1'b1, 32'h80FF_7F01, 5'd1, 0, 0, 0);
    chk("sbyte_value", e_load, 32'hFFFF_FF80);
    // Half store to upper lanes with request stall
    run_op(32'h102, 32'hABCD, RMASK_W, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0, 5'd2, 3, 0, 0);
    // Misaligned word load
    run_op(32'h101, 32'h0, RMASK_W, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd3, 0, 0, 0);
    // Downstream backpressure
    run_op(32'h40, 32'h0, RMASK_W, 8'h0, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF, 5'd4, 1, 2, 4);
    // ren and wen together behave as a load
    run_op(32'h202, 32'h5555, RMASK_H, 8'h03, 1'b1, 1'b1, 1'b1, 32'h8001_0000, 5'd6, 0, 1, 1);

    // Reset while waiting for a load response
    @(negedge clk);
    alu_result_input = 32'h200; ren_input = 1'b1; wen_input = 1'b0;
    rmask_input = RMASK_W; rd_input = 5'd7; lsu_receive_valid = 1'b1;
    @(negedge clk);
    lsu_receive_valid = 1'b0;
    chk("mid_req_valid", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("mid_wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_send_valid", 32'(lsu_send_valid), 32'd0);
    chk("arst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    chk("arst_alu_result", alu_result, 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    chk("arst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("late_send_valid", 32'(lsu_send_valid), 32'd0);
    chk("late_load_data", load_data, 32'd0);
    chk("late_send_ready", 32'(lsu_send_ready), 32'd1);
    run_op(32'h304, 32'hCAFE_F00D, RMASK_W, 8'h0F, 1'b0, 1'b1, 1'b0, 32'h0, 5'd8, 0, 0, 0);

    // Randomized mix of sizes, offsets, directions and stalls
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 3);
      s = $urandom_range(0, 2);
      r_rmask = (s == 0) ? RMASK_B : (s == 1) ? RMASK_H : RMASK_W;
      r_wmask = {4'($urandom), (s == 0) ? WMASK_B : (s == 1) ? WMASK_H : WMASK_W};
      r_addr  = $urandom;
      run_op(r_addr, $urandom, r_rmask, r_wmask, k[0], k[1], 1'($urandom), $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
